// File: rtl/uart_frame_tx.sv
// uart_frame_tx
//
// Frame-level 8N1 UART transmitter. A rising edge on the synchronised
// tx_trigger latches the whole tx_in frame. The frame is then sent byte by
// byte, most significant byte first, with each byte sent LSB first. Bit timing
// uses a 16x oversample tick, which keeps it in step with the board receiver.
//
// Parameters
//   FRAME_BYTES : bytes per frame
//   BR_LIMIT    : system clocks per oversample tick (16 ticks per bit)
//   BR_BITS     : tick counter width, 2**BR_BITS > BR_LIMIT
//
// Ports
//   clk_100MHz : system clock, rising edge
//   reset      : asynchronous active-high reset
//   tx_trigger : level request, may be asynchronous; rising edge starts a frame
//   tx_in      : frame data, byte 0 in the top 8 bits
//   tx         : serial output, idles high
//   busy       : high from frame acceptance to the end of the last stop bit
//   done       : one-cycle pulse on the edge that ends the last stop bit

module uart_frame_tx #(
    parameter int unsigned FRAME_BYTES = 18,
    parameter int unsigned BR_LIMIT    = 672,
    parameter int unsigned BR_BITS     = 10
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    input  logic                     tx_trigger,
    input  logic [8*FRAME_BYTES-1:0] tx_in,
    output logic                     tx,
    output logic                     busy,
    output logic                     done
);

    // A one-byte frame still gets a 1-bit index so no zero-width vector appears.
    localparam int unsigned IdxBits = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int unsigned FrameW  = 8 * FRAME_BYTES;

    localparam logic [BR_BITS-1:0] TickMax = BR_BITS'(BR_LIMIT - 1);
    localparam logic [IdxBits-1:0] LastIdx = IdxBits'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e              state_q;
    logic [BR_BITS-1:0]  tick_cnt_q;
    logic [3:0]          os_cnt_q;
    logic [2:0]          bit_cnt_q;
    logic [IdxBits-1:0]  byte_idx_q;
    logic [FrameW-1:0]   shift_q;

    logic                trig_meta_q;
    logic                trig_sync_q;
    logic                trig_prev_q;

    logic                trig_rise;
    logic                tick;
    logic                bit_end;
    logic [7:0]          cur_byte;

    // Two-flop synchroniser followed by an edge register on the clean level.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            trig_meta_q <= 1'b0;
            trig_sync_q <= 1'b0;
            trig_prev_q <= 1'b0;
        end else begin
            trig_meta_q <= tx_trigger;
            trig_sync_q <= trig_meta_q;
            trig_prev_q <= trig_sync_q;
        end
    end

    assign trig_rise = trig_sync_q & ~trig_prev_q;
    assign tick      = (tick_cnt_q == TickMax);
    // The last tick of the 16-tick bit closes the current bit.
    assign bit_end   = tick & (os_cnt_q == 4'hF);
    // The shift register moves up one byte per byte sent, so the active byte
    // is always the top one.
    assign cur_byte  = shift_q[FrameW-1 -: 8];

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
        end else begin
            done <= 1'b0;

            if (state_q == StIdle) begin
                tick_cnt_q <= '0;
                os_cnt_q   <= '0;
            end else begin
                tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
                if (tick) begin
                    os_cnt_q <= os_cnt_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    tx <= 1'b1;
                    // Edges arriving in any other state are dropped, not queued.
                    if (trig_rise) begin
                        shift_q    <= tx_in;
                        byte_idx_q <= '0;
                        bit_cnt_q  <= '0;
                        busy       <= 1'b1;
                        tx         <= 1'b0;
                        state_q    <= StStart;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        tx        <= cur_byte[0];
                        state_q   <= StData;
                    end
                end

                StData: begin
                    if (bit_end) begin
                        if (bit_cnt_q == 3'd7) begin
                            tx      <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx        <= cur_byte[bit_cnt_q + 3'd1];
                        end
                    end
                end

                StStop: begin
                    if (bit_end) begin
                        if (byte_idx_q == LastIdx) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            tx      <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            // The next start bit begins immediately, with no idle gap.
                            byte_idx_q <= byte_idx_q + 1'b1;
                            shift_q    <= shift_q << 8;
                            tx         <= 1'b0;
                            state_q    <= StStart;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx. One small instance (2 bytes, BR_LIMIT=4) is
// checked cycle by cycle against a waveform model. One full-width instance
// (18 bytes, reduced BR_LIMIT) is decoded by a mid-bit sampling receiver.

module tb_uart_frame_tx;

    localparam int unsigned FbS  = 2;
    localparam int unsigned BrS  = 4;
    localparam int          PerS = 16 * BrS;
    localparam int          LenS = FbS * 10 * PerS;

    localparam int unsigned FbB  = 18;
    localparam int unsigned BrB  = 2;
    localparam int          PerB = 16 * BrB;
    localparam int          LenB = FbB * 10 * PerB;

    logic clk;
    logic reset;

    logic                 trig_s;
    logic [8*FbS-1:0]     din_s;
    logic                 tx_s;
    logic                 busy_s;
    logic                 done_s;

    logic                 trig_b;
    logic [8*FbB-1:0]     din_b;
    logic                 tx_b;
    logic                 busy_b;
    logic                 done_b;

    int checks   = 0;
    int failures = 0;

    uart_frame_tx #(
        .FRAME_BYTES(FbS),
        .BR_LIMIT   (BrS),
        .BR_BITS    (3)
    ) u_small (
        .clk_100MHz(clk),
        .reset     (reset),
        .tx_trigger(trig_s),
        .tx_in     (din_s),
        .tx        (tx_s),
        .busy      (busy_s),
        .done      (done_s)
    );

    uart_frame_tx #(
        .FRAME_BYTES(FbB),
        .BR_LIMIT   (BrB),
        .BR_BITS    (2)
    ) u_big (
        .clk_100MHz(clk),
        .reset     (reset),
        .tx_trigger(trig_b),
        .tx_in     (din_b),
        .tx        (tx_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level t cycles after acceptance. Each byte is 10 bit
    // periods: a 0 start bit, 8 data bits LSB first, then a 1 stop bit.
    function automatic logic exp_tx(input logic [15:0] data, input int t);
        int         byte_no;
        int         bit_no;
        logic [7:0] b;
        byte_no = t / (10 * PerS);
        bit_no  = (t % (10 * PerS)) / PerS;
        b       = data[15 - 8*byte_no -: 8];
        if (bit_no == 0) return 1'b0;
        if (bit_no == 9) return 1'b1;
        return b[bit_no - 1];
    endfunction

    // Returns 1 ns after the edge on which the small DUT raised busy.
    task automatic wait_accept(input string tag);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (busy_s === 1'b1) break;
        end
        check_eq({tag, "_accept"}, busy_s, 1'b1);
    endtask

    // Samples t = 0..LenS at negedges, starting just after the acceptance edge.
    task automatic watch_frame(input logic [15:0] data, input string tag, input bit pulses,
                               input bit hold, input bit scramble, input bit b2b);
        int errs;
        errs = 0;
        for (int t = 0; t <= LenS; t++) begin
            @(negedge clk);
            if (t < LenS) begin
                if (tx_s !== exp_tx(data, t) || busy_s !== 1'b1 || done_s !== 1'b0) errs++;
            end else begin
                if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b1) errs++;
            end
            if (!hold && t == 5) trig_s = 1'b0;
            if (pulses && (t == 100 || t == 400 || t == 900)) trig_s = 1'b1;
            if (pulses && (t == 106 || t == 406 || t == 906)) trig_s = 1'b0;
            if (scramble && t == 0) din_s = 16'hFFFF;
            // Timed so the synchronised edge reaches IDLE in its first cycle.
            if (b2b && t == LenS - 2) trig_s = 1'b1;
        end
        check_eq({tag, "_wave"}, errs, 0);
    endtask

    task automatic idle_check(input int n, input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx_s !== 1'b1 || busy_s !== 1'b0 || done_s !== 1'b0) errs++;
        end
        check_eq({tag, "_idle"}, errs, 0);
    endtask

    initial begin
        logic [15:0] d;
        int          r;
        int          busy_cnt;
        int          done_cnt;
        int          frame_errs;
        logic        rx_bits [0:FbB*10-1];
        logic [7:0]  ch;
        logic [8*FbB-1:0] msg;

        reset  = 1'b1;
        trig_s = 1'b0;
        trig_b = 1'b0;
        din_s  = 16'h4142;
        msg    = "{hi_i'm_your_army}";
        din_b  = msg;

        #2;
        check_eq("rst_tx",    tx_s,   1'b1);
        check_eq("rst_busy",  busy_s, 1'b0);
        check_eq("rst_done",  done_s, 1'b0);
        check_eq("rst_tx_b",  tx_b,   1'b1);
        check_eq("rst_busy_b", busy_b, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle_check(1000, "post_reset");

        // Latency and single frame.
        @(negedge clk);
        trig_s = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("lat_pre_tx",   tx_s,   1'b1);
        check_eq("lat_pre_busy", busy_s, 1'b0);
        @(posedge clk);
        #1;
        check_eq("lat_tx",   tx_s,   1'b0);
        check_eq("lat_busy", busy_s, 1'b1);
        watch_frame(16'h4142, "single", 1'b0, 1'b0, 1'b0, 1'b0);
        idle_check(20, "single");

        // Retrigger pulses during a frame are discarded.
        @(negedge clk);
        trig_s = 1'b1;
        wait_accept("retrig");
        watch_frame(16'h4142, "retrig", 1'b1, 1'b0, 1'b0, 1'b0);
        idle_check(2000, "retrig");

        // Held trigger gives one frame only.
        @(negedge clk);
        trig_s = 1'b1;
        wait_accept("hold");
        watch_frame(16'h4142, "hold", 1'b0, 1'b1, 1'b0, 1'b0);
        idle_check(2 * LenS, "hold");
        trig_s = 1'b0;
        idle_check(10, "hold_rel");

        // Data stability, then a back-to-back frame with no idle bit.
        @(negedge clk);
        trig_s = 1'b1;
        wait_accept("stable");
        watch_frame(16'h4142, "stable", 1'b0, 1'b0, 1'b1, 1'b1);
        watch_frame(16'hFFFF, "b2b", 1'b0, 1'b0, 1'b0, 1'b0);
        idle_check(20, "b2b");

        // Random data frames.
        for (int k = 0; k < 3; k++) begin
            d = 16'($urandom);
            @(negedge clk);
            din_s  = d;
            trig_s = 1'b1;
            wait_accept("rnd");
            watch_frame(d, "rnd", 1'b0, 1'b0, 1'b0, 1'b0);
            idle_check(5, "rnd");
        end

        // Asynchronous reset at random points; the first lands in a 0 data bit.
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 16'h4142 : 16'($urandom);
            r = (k == 0) ? 129 + int'($urandom_range(0, 62)) : 2 + int'($urandom_range(0, LenS - 10));
            @(negedge clk);
            din_s  = d;
            trig_s = 1'b1;
            wait_accept("rst_mid");
            for (int i = 0; i < r; i++) begin
                @(negedge clk);
                trig_s = 1'b0;
            end
            check_eq("rst_mid_pre_tx", tx_s, exp_tx(d, r - 1));
            @(posedge clk);
            #3;
            reset = 1'b1;
            #1;
            check_eq("rst_mid_tx",   tx_s,   1'b1);
            check_eq("rst_mid_busy", busy_s, 1'b0);
            check_eq("rst_mid_done", done_s, 1'b0);
            repeat (3) @(negedge clk);
            reset = 1'b0;
            idle_check(1000, "rst_mid");
        end

        // Full-width frame decoded by a mid-bit sampling receiver.
        @(negedge clk);
        trig_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (busy_b === 1'b1) break;
        end
        check_eq("big_accept", busy_b, 1'b1);
        busy_cnt = 0;
        done_cnt = 0;
        for (int t = 0; t < LenB + 8; t++) begin
            @(negedge clk);
            if (t == 5) trig_b = 1'b0;
            if (busy_b === 1'b1) busy_cnt++;
            if (done_b === 1'b1) done_cnt++;
            if (t < LenB && (t % PerB) == PerB / 2) rx_bits[t / PerB] = tx_b;
        end
        frame_errs = 0;
        for (int b = 0; b < int'(FbB); b++) begin
            if (rx_bits[10*b] !== 1'b0 || rx_bits[10*b + 9] !== 1'b1) frame_errs++;
            for (int j = 0; j < 8; j++) ch[j] = rx_bits[10*b + 1 + j];
            check_eq($sformatf("big_char%0d", b), ch, msg[8*FbB - 1 - 8*b -: 8]);
        end
        check_eq("big_framing", frame_errs, 0);
        check_eq("big_busy_len", busy_cnt, LenB);
        check_eq("big_done_cnt", done_cnt, 1);
        check_eq("big_idle_tx", tx_b, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Frame-level UART transmitter for the badge's 8N1 serial link, sized to match the board's existing receiver. On a trigger it latches a packed multi-byte frame and serialises it, one byte after another, onto a single `tx` line. It uses the same 16x oversampled baud tick scheme as the receiver, so one `BR_LIMIT` and `BR_BITS` setting serves both directions. It sits between the top-level controller (frame source, button/command trigger) and the interconnect/PMOD pin driving `tx`.

## Interface
- `FRAME_BYTES`, 18: number of bytes per frame.
- `BR_LIMIT`, 672: system clocks per oversample tick (tick rate = 16x baud).
- `BR_BITS`, 10: width of the tick counter; must satisfy 2^BR_BITS > BR_LIMIT.
- `clk_100MHz` input 1: the single clock. All logic is synchronous to its rising edge.
- `reset` input 1: asynchronous, active-high. Clears all state immediately.
- `tx_trigger` input 1: level request, possibly asynchronous (button). Internally synchronised and rising-edge detected.
- `tx_in` input 8*FRAME_BYTES: frame data. Byte 0 = `tx_in[8*FRAME_BYTES-1 -: 8]`, so string literals transmit in text order.
- `tx` output 1: serial line. Idles high.
- `busy` output 1: high from frame acceptance until the end of the last stop bit.
- `done` output 1: one-cycle pulse when a frame completes.

## Operation
- **Reset values:** `tx`=1, `busy`=0, `done`=0, state=IDLE, all counters 0. The synchroniser flops reset to 0.
- **Trigger path:**
  - 2-flop synchroniser, then an edge detect on the synchronised level.
  - A rising edge seen while busy is discarded; there is no queueing.
  - A trigger held high produces exactly one frame.
  - To start another frame, the trigger must go low and then high again.
- **Acceptance (IDLE only):**
  - Copy `tx_in` into a shift register and clear the byte index.
  - Clear the tick counter and the oversample counter.
  - Set `busy`=1 and enter START.
  - Changes on `tx_in` after acceptance do not affect the frame in flight.
- **Tick generator:**
  - `tick_cnt` counts 0..BR_LIMIT-1.
  - `tick` asserts in the cycle where `tick_cnt`==BR_LIMIT-1, then the counter wraps to 0.
  - Free-running while busy; held at 0 in IDLE.
- **Bit timing:** each bit lasts 16 ticks, counted by a 4-bit `os_cnt` that wraps 15 to 0.
- **States:**
  - IDLE: `tx`=1.
  - START: `tx`=0 for 16 ticks, then DATA with `bit_cnt`=0.
  - DATA: `tx`=current byte[`bit_cnt`], sent LSB first. After 16 ticks, `bit_cnt`+1; after bit 7, enter STOP.
  - STOP: `tx`=1 for 16 ticks. Then:
    - if `byte_idx`==FRAME_BYTES-1, go to IDLE and pulse `done`;
    - otherwise increment `byte_idx`, shift the next byte in, and go to START.
- **Inter-byte timing:** no idle gap is inserted between bytes. The next start bit follows the stop bit immediately.
- **Widths:** `byte_idx` uses $clog2(FRAME_BYTES) bits; `bit_cnt` is 3 bits. No counter may overflow at FRAME_BYTES=1.
- **Reset mid-frame:** `tx` returns high asynchronously and `busy` drops. No `done` pulse is emitted; the partial frame is abandoned.

## Timing
- **Trigger to start bit:** a `tx_trigger` rising edge in cycle N (meeting setup) is accepted in cycle N+3 (2 sync stages + edge register). `tx` goes low and `busy` goes high on that edge.
- **Bit period:** exactly 16*BR_LIMIT clocks per bit, including start and stop bits.
- **Frame length:** FRAME_BYTES*10*16*BR_LIMIT clocks from the first falling edge of `tx` to the end of the last stop bit.
- **End of frame:** `done` is high for one cycle, and `busy` falls, on the same edge that ends the last stop bit.
- **Back-to-back frames:** a new trigger edge can be accepted in the cycle after `busy` falls.

## Test plan
- **Reset/idle:** assert `reset` at random times, including mid-DATA.
  - `tx`=1, `busy`=0 and `done`=0 within the same cycle, without waiting for a clock edge.
  - `tx` stays 1 for 1000 cycles after release with no trigger.
- **Single frame** (FRAME_BYTES=2, BR_LIMIT=4, `tx_in`=16'h4142, one trigger pulse):
  - `tx` shows start 0, bits 1,0,0,0,0,0,1,0, stop 1; then start 0, bits 0,1,0,0,0,0,1,0, stop 1.
  - Each bit lasts 64 cycles; total 1280 cycles.
  - `done` is a single one-cycle pulse.
- **Latency:** trigger rising in cycle N leads to `tx` low and `busy` high at cycle N+3.
- **Retrigger and held trigger:**
  - Pulse `tx_trigger` three times during a frame: still exactly one frame and one `done`.
  - Hold `tx_trigger` high for 3 frame lengths: exactly one frame.
- **Data stability and back-to-back:**
  - Change `tx_in` to 16'hFFFF one cycle after acceptance: bytes 0x41, 0x42 are still sent.
  - Trigger again in the cycle after `done`: the second frame starts with no idle bit.
- **Full-size frame** (FRAME_BYTES=18, BR_LIMIT=672, 18-byte ASCII string "{hi_i'm_your_army}"):
  - The bench receiver decodes all 18 characters in order.
  - Frame time is 18*10*16*672 = 1,935,360 cycles.
